// File: rtl/ram1_uart_ctrl.sv
// Memory-stage controller that shares one 16-bit bus between the RAM1 SRAM and a UART.
// Requests at or above the UART data address are serviced; lower addresses are ignored.
module ram1_uart_ctrl #(
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [15:0] req_addr_i,
    input  logic [15:0] req_wdata_i,
    output logic        stall_o,
    output logic [15:0] rdata_o,
    output logic        rdata_valid_o,
    output logic [17:0] ram1_addr_o,
    inout  wire  [15:0] ram1_data_io,
    output logic        ram1_en_o,
    output logic        ram1_oe_o,
    output logic        ram1_we_o,
    output logic        rdn_o,
    output logic        wrn_o,
    input  logic        data_ready_i,
    input  logic        tbre_i,
    input  logic        tsre_i
);

    typedef enum logic [3:0] {
        IDLE,
        RAM_RD,
        RAM_WR1,
        RAM_WR2,
        UART_WAIT_DR,
        UART_RD1,
        UART_RD2,
        UART_WR1,
        UART_WR2,
        UART_WAIT_TX,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        write_q;
    logic [15:0] rdata_q;
    logic        rvalid_q;
    logic        en_q, oe_q, we_q, rdn_q, wrn_q;
    logic        drive_q;

    logic accept;
    logic is_data;
    logic is_stat;
    logic is_read_d;

    assign accept  = (state_q == IDLE) && req_valid_i && (req_addr_i >= UART_DATA_ADDR);
    assign is_data = (req_addr_i == UART_DATA_ADDR);
    assign is_stat = (req_addr_i == UART_STAT_ADDR);

    // The transaction's direction comes from the live request on the accept edge,
    // because the latched copy is only written on that same edge.
    assign is_read_d = accept ? !req_write_i : !write_q;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_stat)      state_d = DONE;
                    else if (is_data) state_d = req_write_i ? UART_WR1 : UART_WAIT_DR;
                    else              state_d = req_write_i ? RAM_WR1  : RAM_RD;
                end
            end
            RAM_RD:       state_d = DONE;
            RAM_WR1:      state_d = RAM_WR2;
            RAM_WR2:      state_d = DONE;
            UART_WAIT_DR: if (data_ready_i) state_d = UART_RD1;
            UART_RD1:     state_d = UART_RD2;
            UART_RD2:     state_d = DONE;
            UART_WR1:     state_d = UART_WR2;
            UART_WR2:     state_d = UART_WAIT_TX;
            UART_WAIT_TX: if (tbre_i && tsre_i) state_d = DONE;
            DONE:         state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so each one is a clean flop output
    // that is asserted for exactly the cycles spent in the matching state.
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            en_q     <= 1'b1;
            oe_q     <= 1'b1;
            we_q     <= 1'b1;
            rdn_q    <= 1'b1;
            wrn_q    <= 1'b1;
            drive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= !(state_d inside {RAM_RD, RAM_WR1, RAM_WR2});
            oe_q     <= (state_d != RAM_RD);
            we_q     <= (state_d != RAM_WR1);
            rdn_q    <= !(state_d inside {UART_RD1, UART_RD2});
            wrn_q    <= (state_d != UART_WR1);
            drive_q  <= (state_d inside {RAM_WR1, RAM_WR2, UART_WR1, UART_WR2});
            rvalid_q <= (state_d == DONE) && is_read_d;

            if (accept) begin
                addr_q  <= req_addr_i;
                write_q <= req_write_i;
                wdata_q <= req_wdata_i;
                if (is_stat && !req_write_i)
                    rdata_q <= {14'b0, data_ready_i, tbre_i & tsre_i};
            end

            if (state_q == RAM_RD)
                rdata_q <= ram1_data_io;
            else if (state_q == UART_RD2)
                rdata_q <= {8'h00, ram1_data_io[7:0]};
        end
    end

    assign stall_o       = !rst && (accept || !(state_q inside {IDLE, DONE}));
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign ram1_addr_o   = {2'b00, addr_q};
    assign ram1_en_o     = en_q;
    assign ram1_oe_o     = oe_q;
    assign ram1_we_o     = we_q;
    assign rdn_o         = rdn_q;
    assign wrn_o         = wrn_q;
    assign ram1_data_io  = drive_q ? wdata_q : 16'hzzzz;

endmodule

// File: doc/ram1_uart_ctrl.md
RAM1_UART_CTRL -- requirements
Module: ram1_uart_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all other timing below is in clk cycles.
REQ-002 Parameter: UART_DATA_ADDR, default 16'hBF00, UART data register address.
REQ-003 Parameter: UART_STAT_ADDR, default 16'hBF01, UART status register address; addresses >= UART_STAT_ADDR+1 map to RAM1.
REQ-004 Ports, one per line:
  clk  in  1  system clock, rising edge
  rst  in  1  asynchronous reset, active-high
  req_valid_i  in  1  memory-stage access request
  req_write_i  in  1  1 = write, 0 = read
  req_addr_i  in  16  access address
  req_wdata_i  in  16  write data
  stall_o  out  1  hold pipeline; request inputs held stable while high
  rdata_o  out  16  read result
  rdata_valid_o  out  1  rdata_o valid this cycle
  ram1_addr_o  out  18  RAM1 address
  ram1_data_io  inout  16  shared RAM1/UART data bus
  ram1_en_o  out  1  RAM1 chip enable, active-low
  ram1_oe_o  out  1  RAM1 output enable, active-low
  ram1_we_o  out  1  RAM1 write enable, active-low
  rdn_o  out  1  UART read strobe, active-low
  wrn_o  out  1  UART write strobe, active-low
  data_ready_i  in  1  UART receive byte available
  tbre_i  in  1  UART transmit buffer empty
  tsre_i  in  1  UART transmit shift register empty

Function
REQ-005 Accept SHALL occur only in IDLE when req_valid_i=1 and req_addr_i >= UART_DATA_ADDR; lower addresses SHALL be ignored (no stall, no strobes).
REQ-006 On accept, address, write flag and wdata SHALL be latched; later outputs use only latched values.
REQ-007 States SHALL be: IDLE, RAM_RD, RAM_WR1, RAM_WR2, UART_WAIT_DR, UART_RD1, UART_RD2, UART_WR1, UART_WR2, UART_WAIT_TX, DONE.
REQ-008 Transitions from IDLE on accept: RAM1 read->RAM_RD; RAM1 write->RAM_WR1; data read->UART_WAIT_DR; data write->UART_WR1; status read or status write->DONE.
REQ-009 RAM_RD: en=0, oe=0, bus Z; data captured into rdata_o at cycle end; ->DONE.
REQ-010 RAM_WR1: en=0, we=0, bus driven with wdata; ->RAM_WR2. RAM_WR2: en=0, we=1, bus still driven; ->DONE.
REQ-011 UART_WAIT_DR: holds until data_ready_i=1, then ->UART_RD1. UART_RD1: rdn=0; ->UART_RD2. UART_RD2: rdn=0, rdata_o <= {8'h00, bus[7:0]}; ->DONE.
REQ-012 UART_WR1: wrn=0, bus driven; ->UART_WR2. UART_WR2: wrn=1, bus driven; ->UART_WAIT_TX. UART_WAIT_TX: holds until tbre_i & tsre_i, then ->DONE.
REQ-013 Status read SHALL capture rdata_o <= {14'b0, data_ready_i, tbre_i & tsre_i} on the accept edge; status write SHALL have no side effect.
REQ-014 DONE: stall_o=0; rdata_valid_o=1 for reads only; unconditionally ->IDLE; no accept in DONE.
REQ-015 stall_o SHALL be combinational: 1 in IDLE on accept, 1 in every state except IDLE and DONE, else 0.
REQ-016 ram1_en_o SHALL be 1 throughout every UART state; rdn_o/wrn_o SHALL be 1 throughout RAM states; never both devices active.
REQ-017 ram1_data_io SHALL be driven only in RAM_WR1, RAM_WR2, UART_WR1, UART_WR2; otherwise high-Z.
REQ-018 ram1_addr_o SHALL be {2'b00, latched address}; rdata_o holds its value until the next capture.
REQ-019 Latency: status 2 cycles, RAM1 read/write 3 and 4 cycles, UART read 4 + wait cycles, UART write 4 + wait cycles (accept through DONE inclusive).

Reset
REQ-020 rst=1 SHALL immediately force IDLE, stall_o=0, rdata_o=0, rdata_valid_o=0, ram1_en/oe/we=1, rdn_o=wrn_o=1, bus high-Z, including mid-transaction (aborted access not resumed).

Verification
REQ-021 RAM1 read addr 16'hC000, SRAM returns 16'h1234 -> oe=0 one cycle, stall 2 cycles, DONE rdata_o=16'h1234, rdata_valid_o=1.
REQ-022 RAM1 write 16'hBF02 <- 16'hA5A5 -> we low exactly one cycle, bus=16'hA5A5 two cycles, ram1_addr_o=18'h0BF02, stall 3 cycles.
REQ-023 Status read with data_ready_i=1, tbre_i=1, tsre_i=0 -> rdata_o=16'h0002 in DONE, cycle after accept.
REQ-024 UART read, data_ready_i raised 5 cycles late, bus 16'hFF41 -> rdn low 2 cycles after data_ready, rdata_o=16'h0041, ram1_en_o stays 1.
REQ-025 UART write 16'h0055, tsre_i held 0 for 10 cycles -> wrn low one cycle, stall held until tbre&tsre, then DONE; rst asserted in UART_WAIT_TX -> all strobes 1, IDLE next edge.
REQ-026 req_valid_i with addr 16'h8000 -> stall_o=0, no strobe toggles.
